alu_result_checker: RTL and testbench

Sequential response checker that sits directly downstream of the 4-bit ALU under test in the mutation-testing flow. Each cycle it captures one applied vector (A, B, opcode) plus the ALU's result/zero_flag, and compares them against an internal golden ALU model. It counts vectors and mismatches, records which opcodes exposed a fault, and latches the first failing vector. A nonzero mismatch count marks the mutant as killed.

---
 rtl/alu_chk_pkg.sv | 33 +++
 rtl/alu_golden_ref.sv | 36 +++
 rtl/alu_result_checker.sv | 136 +++++++++++++
 tb/tb_alu_result_checker.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_chk_pkg.sv
// rtl/alu_chk_pkg.sv - shared constants, FSM encoding and MISR step for the ALU result checker
//
// Contents:
//   OP_ADD..OP_NOP   opcode constants (3'b000..3'b111)
//   chk_state_t      checker FSM encoding (ST_IDLE, ST_CHECK, ST_HALT)
//   MISR_POLY/SEED   signature register polynomial x^16+x^12+x^5+1 and seed
//   misr_step()      one MISR update with a 16-bit parallel input word
package alu_chk_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_EQ  = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_HALT  = 2'd2
    } chk_state_t;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    // Galois-style shift with feedback from the MSB, then fold in the new word.
    function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [15:0] din);
        misr_step = {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ din;
    endfunction

endpackage

// File: rtl/alu_golden_ref.sv
// rtl/alu_golden_ref.sv - combinational golden model of the ALU under test
//
// Ports:
//   A, B        operands (WIDTH)
//   opcode      operation select (3)
//   exp_result  expected result, modulo 2^WIDTH (WIDTH)
//   exp_zero    expected zero flag (exp_result == 0)
module alu_golden_ref
    import alu_chk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       opcode,
    output logic [WIDTH-1:0] exp_result,
    output logic             exp_zero
);

    always_comb begin
        exp_result = '0;
        case (opcode)
            OP_ADD:  exp_result = A + B;
            OP_SUB:  exp_result = A - B;
            OP_AND:  exp_result = A & B;
            OP_OR:   exp_result = A | B;
            OP_XOR:  exp_result = A ^ B;
            OP_EQ:   exp_result = WIDTH'(A == B);
            OP_LT:   exp_result = WIDTH'(A < B);
            default: exp_result = '0;
        endcase
    end

    assign exp_zero = (exp_result == '0);

endmodule

// File: rtl/alu_result_checker.sv
// rtl/alu_result_checker.sv - compares ALU responses to a golden model and keeps kill statistics
//
// Optional feature macro: ALU_CHK_MISR_EN adds a 16-bit response signature output.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, finish     control pulses: clear stats and enter CHECK / enter HALT
//   in_valid/in_ready vector handshake (ready only while checking)
//   A, B, opcode      vector applied to the ALU under test
//   dut_result/zero   response of the ALU under test
//   chk_valid         one-cycle pulse per completed compare, chk_mismatch qualifies it
//   vec_count         accepted vectors (saturating), fail_count mismatches (saturating)
//   fail_op_map       bit k set when any opcode-k vector failed
//   first_fail_*      vector, expected and observed response of the first failure
//   mutant_killed     fail_count != 0
//   halted            FSM in HALT
//   signature         MISR over accepted responses (ALU_CHK_MISR_EN only)
module alu_result_checker
    import alu_chk_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int CNT_W        = 16,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 finish,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           opcode,
    input  logic [WIDTH-1:0]     dut_result,
    input  logic                 dut_zero,
    output logic                 chk_valid,
    output logic                 chk_mismatch,
    output logic [CNT_W-1:0]     vec_count,
    output logic [CNT_W-1:0]     fail_count,
    output logic [7:0]           fail_op_map,
    output logic [2*WIDTH+2:0]   first_fail_vec,
    output logic [WIDTH:0]       first_fail_exp,
    output logic [WIDTH:0]       first_fail_got,
    output logic                 mutant_killed,
    output logic                 halted
`ifdef ALU_CHK_MISR_EN
    ,
    output logic [15:0]          signature
`endif
);

    chk_state_t       state;
    logic [WIDTH-1:0] exp_result;
    logic             exp_zero;
    logic             mismatch;
    logic             accept;

    alu_golden_ref #(.WIDTH(WIDTH)) u_golden (
        .A          (A),
        .B          (B),
        .opcode     (opcode),
        .exp_result (exp_result),
        .exp_zero   (exp_zero)
    );

    assign mismatch      = (dut_result != exp_result) || (dut_zero != exp_zero);
    assign in_ready      = (state == ST_CHECK);
    assign accept        = in_valid && in_ready;
    assign mutant_killed = (fail_count != '0);
    assign halted        = (state == ST_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            chk_valid      <= 1'b0;
            chk_mismatch   <= 1'b0;
            vec_count      <= '0;
            fail_count     <= '0;
            fail_op_map    <= '0;
            first_fail_vec <= '0;
            first_fail_exp <= '0;
            first_fail_got <= '0;
        end else if (start) begin
            // start wins over any vector on the same edge: the vector is dropped.
            state          <= ST_CHECK;
            chk_valid      <= 1'b0;
            chk_mismatch   <= 1'b0;
            vec_count      <= '0;
            fail_count     <= '0;
            fail_op_map    <= '0;
            first_fail_vec <= '0;
            first_fail_exp <= '0;
            first_fail_got <= '0;
        end else begin
            chk_valid    <= accept;
            chk_mismatch <= accept && mismatch;
            if (accept) begin
                if (vec_count != {CNT_W{1'b1}}) begin
                    vec_count <= vec_count + 1'b1;
                end
                if (mismatch) begin
                    if (fail_count != {CNT_W{1'b1}}) begin
                        fail_count <= fail_count + 1'b1;
                    end
                    fail_op_map[opcode] <= 1'b1;
                    // fail_count is nonzero once saturated, so capture stays one-shot.
                    if (fail_count == '0) begin
                        first_fail_vec <= {A, B, opcode};
                        first_fail_exp <= {exp_zero, exp_result};
                        first_fail_got <= {dut_zero, dut_result};
                    end
                end
            end
            case (state)
                ST_CHECK: begin
                    if (finish || ((STOP_ON_FAIL != 0) && accept && mismatch)) begin
                        state <= ST_HALT;
                    end
                end
                default: state <= state;
            endcase
        end
    end

`ifdef ALU_CHK_MISR_EN
    // Only accepted vectors fold in, so the signature is naturally frozen outside CHECK.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            signature <= MISR_SEED;
        end else if (accept) begin
            signature <= misr_step(signature, 16'({dut_zero, dut_result}));
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_checker.sv
// tb/tb_alu_result_checker.sv - self-checking bench for alu_result_checker (three configurations)
module tb_alu_result_checker;

    logic       clk = 1'b0;
    logic       rst, start, finish, in_valid, dz;
    logic [3:0] va, vb, dr;
    logic [2:0] op;

    always #5 clk = ~clk;

    // u0: defaults, u1: STOP_ON_FAIL=1, u2: CNT_W=2
    logic        rdy0, cv0, cm0, kill0, halt0;
    logic [15:0] vc0, fc0;
    logic [7:0]  map0;
    logic [10:0] ffv0;
    logic [4:0]  ffe0, ffg0;
    logic        rdy1, cv1, cm1, kill1, halt1;
    logic [15:0] vc1, fc1;
    logic [7:0]  map1;
    logic [10:0] ffv1;
    logic [4:0]  ffe1, ffg1;
    logic        rdy2, cv2, cm2, kill2, halt2;
    logic [1:0]  vc2, fc2;
    logic [7:0]  map2;
    logic [10:0] ffv2;
    logic [4:0]  ffe2, ffg2;
`ifdef ALU_CHK_MISR_EN
    logic [15:0] sig0, sig1, sig2;
`endif

    alu_result_checker #(.WIDTH(4), .CNT_W(16), .STOP_ON_FAIL(0)) u0 (
        .clk(clk), .rst(rst), .start(start), .finish(finish), .in_valid(in_valid), .in_ready(rdy0),
        .A(va), .B(vb), .opcode(op), .dut_result(dr), .dut_zero(dz),
        .chk_valid(cv0), .chk_mismatch(cm0), .vec_count(vc0), .fail_count(fc0), .fail_op_map(map0),
        .first_fail_vec(ffv0), .first_fail_exp(ffe0), .first_fail_got(ffg0),
        .mutant_killed(kill0), .halted(halt0)
`ifdef ALU_CHK_MISR_EN
        , .signature(sig0)
`endif
    );

    alu_result_checker #(.WIDTH(4), .CNT_W(16), .STOP_ON_FAIL(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .finish(finish), .in_valid(in_valid), .in_ready(rdy1),
        .A(va), .B(vb), .opcode(op), .dut_result(dr), .dut_zero(dz),
        .chk_valid(cv1), .chk_mismatch(cm1), .vec_count(vc1), .fail_count(fc1), .fail_op_map(map1),
        .first_fail_vec(ffv1), .first_fail_exp(ffe1), .first_fail_got(ffg1),
        .mutant_killed(kill1), .halted(halt1)
`ifdef ALU_CHK_MISR_EN
        , .signature(sig1)
`endif
    );

    alu_result_checker #(.WIDTH(4), .CNT_W(2), .STOP_ON_FAIL(0)) u2 (
        .clk(clk), .rst(rst), .start(start), .finish(finish), .in_valid(in_valid), .in_ready(rdy2),
        .A(va), .B(vb), .opcode(op), .dut_result(dr), .dut_zero(dz),
        .chk_valid(cv2), .chk_mismatch(cm2), .vec_count(vc2), .fail_count(fc2), .fail_op_map(map2),
        .first_fail_vec(ffv2), .first_fail_exp(ffe2), .first_fail_got(ffg2),
        .mutant_killed(kill2), .halted(halt2)
`ifdef ALU_CHK_MISR_EN
        , .signature(sig2)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, one slot per instance.
    bit          m_run[3], m_halt[3], m_cv[3], m_cm[3];
    logic [15:0] m_vec[3], m_fail[3];
    logic [7:0]  m_map[3];
    logic [10:0] m_ffv[3];
    logic [4:0]  m_ffe[3], m_ffg[3];

    // Returns {zero, result} computed with plain integer arithmetic.
    function automatic logic [4:0] golden(input logic [3:0] x, input logic [3:0] y, input logic [2:0] o);
        int r;
        case (o)
            3'd0:    r = (int'(x) + int'(y)) % 16;
            3'd1:    r = (int'(x) - int'(y) + 16) % 16;
            3'd2:    r = int'(x & y);
            3'd3:    r = int'(x | y);
            3'd4:    r = int'(x ^ y);
            3'd5:    r = (x == y) ? 1 : 0;
            3'd6:    r = (x < y) ? 1 : 0;
            default: r = 0;
        endcase
        return {(r == 0), r[3:0]};
    endfunction

    task automatic model_clear(input int i);
        m_vec[i] = 0; m_fail[i] = 0; m_map[i] = 0;
        m_ffv[i] = 0; m_ffe[i] = 0; m_ffg[i] = 0;
        m_cv[i] = 0; m_cm[i] = 0;
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            logic [15:0] cmax;
            logic [4:0]  e;
            bit          acc, mis;
            cmax = (i == 2) ? 16'd3 : 16'hFFFF;
            e    = golden(va, vb, op);
            acc  = m_run[i] && in_valid;
            mis  = (e != {dz, dr});
            if (rst) begin
                model_clear(i); m_run[i] = 0; m_halt[i] = 0;
            end else if (start) begin
                model_clear(i); m_run[i] = 1; m_halt[i] = 0;
            end else begin
                m_cv[i] = acc;
                m_cm[i] = acc && mis;
                if (acc) begin
                    if (m_vec[i] < cmax) m_vec[i] = m_vec[i] + 1;
                    if (mis) begin
                        if (m_fail[i] == 0) begin
                            m_ffv[i] = {va, vb, op}; m_ffe[i] = e; m_ffg[i] = {dz, dr};
                        end
                        if (m_fail[i] < cmax) m_fail[i] = m_fail[i] + 1;
                        m_map[i][op] = 1'b1;
                    end
                end
                if (m_run[i] && (finish || (i == 1 && acc && mis))) begin
                    m_run[i] = 0; m_halt[i] = 1;
                end
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input logic [3:0] x, input logic [3:0] y, input logic [2:0] o,
                           input logic [3:0] r, input logic z);
        in_valid = 1'b1; va = x; vb = y; op = o; dr = r; dz = z;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; finish = 0; in_valid = 0; va = 0; vb = 0; op = 0; dr = 0; dz = 0;
        cycle(); cycle();
        rst = 1'b0;
        n_checks++; if ({rdy0, cv0, cm0, vc0, fc0, map0, ffv0, ffe0, ffg0, kill0, halt0} !== '0) begin n_errors++; $display("FAIL reset_u0: got %h required 0", {rdy0, cv0, cm0, vc0, fc0, map0, ffv0, ffe0, ffg0, kill0, halt0}); end
        n_checks++; if ({rdy1, halt1, vc1, rdy2, halt2, vc2} !== '0) begin n_errors++; $display("FAIL reset_u1u2: got %h required 0", {rdy1, halt1, vc1, rdy2, halt2, vc2}); end
    endtask

    task automatic test_directed();
        start = 1; cycle(); start = 0;
        n_checks++; if (rdy0 !== 1'b1) begin n_errors++; $display("FAIL start_ready: got %b required 1", rdy0); end
        set_vec(4'd3, 4'd5, 3'b000, 4'd8, 1'b0); cycle();
        n_checks++; if ({cv0, cm0} !== 2'b10) begin n_errors++; $display("FAIL add_pass_flags: got %b required 10", {cv0, cm0}); end
        n_checks++; if (vc0 !== 16'd1 || fc0 !== 16'd0 || kill0 !== 1'b0) begin n_errors++; $display("FAIL add_pass_counts: got vc=%0d fc=%0d kill=%b required 1 0 0", vc0, fc0, kill0); end
        set_vec(4'b1100, 4'b1010, 3'b010, 4'b1110, 1'b0); cycle();
        n_checks++; if ({cv0, cm0, fc0, map0} !== {2'b11, 16'd1, 8'h04}) begin n_errors++; $display("FAIL and_or_stats: got cm=%b fc=%0d map=%h required 1 1 04", cm0, fc0, map0); end
        n_checks++; if (ffv0 !== {4'hC, 4'hA, 3'd2} || ffe0 !== 5'b0_1000 || ffg0 !== 5'b0_1110) begin n_errors++; $display("FAIL and_or_first: got %h %h %h required %h 08 0e", ffv0, ffe0, ffg0, {4'hC, 4'hA, 3'd2}); end
        n_checks++; if (kill0 !== 1'b1) begin n_errors++; $display("FAIL killed: got %b required 1", kill0); end
        set_vec(4'($urandom), 4'($urandom), 3'b111, 4'd0, 1'b0); cycle();
        n_checks++; if ({cm0, fc0, map0} !== {1'b1, 16'd2, 8'h84}) begin n_errors++; $display("FAIL zero_flag_fault: got cm=%b fc=%0d map=%h required 1 2 84", cm0, fc0, map0); end
        n_checks++; if (ffv0 !== {4'hC, 4'hA, 3'd2}) begin n_errors++; $display("FAIL first_held: got %h required %h", ffv0, {4'hC, 4'hA, 3'd2}); end
        in_valid = 0; cycle();
        n_checks++; if ({cv0, vc0} !== {1'b0, 16'd3}) begin n_errors++; $display("FAIL idle_cycle: got cv=%b vc=%0d required 0 3", cv0, vc0); end
    endtask

    task automatic test_stop_on_fail();
        start = 1; cycle(); start = 0;
        set_vec(4'd1, 4'd2, 3'b000, 4'd3, 1'b0); cycle();
        n_checks++; if ({rdy1, vc1} !== {1'b1, 16'd1}) begin n_errors++; $display("FAIL stop_v1: got rdy=%b vc=%0d required 1 1", rdy1, vc1); end
        set_vec(4'd5, 4'd2, 3'b001, 4'd0, 1'b1); cycle();
        n_checks++; if ({rdy1, halt1, cm1, vc1} !== {3'b011, 16'd2}) begin n_errors++; $display("FAIL stop_v2: got rdy=%b halt=%b cm=%b vc=%0d required 0 1 1 2", rdy1, halt1, cm1, vc1); end
        set_vec(4'd2, 4'd2, 3'b101, 4'd1, 1'b0); cycle();
        n_checks++; if ({cv1, halt1, vc1} !== {2'b01, 16'd2}) begin n_errors++; $display("FAIL stop_v3: got cv=%b halt=%b vc=%0d required 0 1 2", cv1, halt1, vc1); end
        n_checks++; if ({halt0, vc0} !== {1'b0, 16'd3}) begin n_errors++; $display("FAIL nostop_u0: got halt=%b vc=%0d required 0 3", halt0, vc0); end
        in_valid = 0;
    endtask

    task automatic test_saturation();
        logic [4:0] e;
        start = 1; cycle(); start = 0;
        set_vec(4'd9, 4'd6, 3'b100, 4'd0, 1'b1); cycle();
        for (int k = 0; k < 4; k++) begin
            va = 4'($urandom); vb = 4'($urandom); op = 3'b000;
            e = golden(va, vb, op);
            dr = e[3:0] + 4'd1; dz = (dr == 4'd0);
            cycle();
        end
        in_valid = 0;
        n_checks++; if ({vc2, fc2} !== 4'b1111) begin n_errors++; $display("FAIL sat_counts: got vc=%0d fc=%0d required 3 3", vc2, fc2); end
        n_checks++; if (ffv2 !== {4'd9, 4'd6, 3'd4} || ffe2 !== 5'b0_1111 || ffg2 !== 5'b1_0000) begin n_errors++; $display("FAIL sat_first: got %h %h %h required %h 0f 10", ffv2, ffe2, ffg2, {4'd9, 4'd6, 3'd4}); end
        n_checks++; if ({vc0, fc0} !== {16'd5, 16'd5}) begin n_errors++; $display("FAIL nosat_u0: got vc=%0d fc=%0d required 5 5", vc0, fc0); end
    endtask

    task automatic test_start_in_halt();
        in_valid = 0; finish = 1; cycle(); finish = 0;
        n_checks++; if ({halt0, rdy0} !== 2'b10) begin n_errors++; $display("FAIL finish_halt: got halt=%b rdy=%b required 1 0", halt0, rdy0); end
        start = 1; finish = 1; set_vec(4'd1, 4'd1, 3'b000, 4'd7, 1'b0); cycle();
        start = 0; finish = 0; in_valid = 0;
        n_checks++; if ({halt0, rdy0, cv0} !== 3'b010) begin n_errors++; $display("FAIL restart_state: got halt=%b rdy=%b cv=%b required 0 1 0", halt0, rdy0, cv0); end
        n_checks++; if ({vc0, fc0, map0, ffv0, ffe0, ffg0, kill0} !== '0) begin n_errors++; $display("FAIL restart_clear: got %h required 0", {vc0, fc0, map0, ffv0, ffe0, ffg0, kill0}); end
    endtask

    task automatic test_reset_midrun();
        start = 1; cycle(); start = 0;
        for (int k = 0; k < 3; k++) begin
            set_vec(4'($urandom), 4'($urandom), 3'($urandom), 4'($urandom), 1'($urandom)); cycle();
        end
        rst = 1; cycle(); rst = 0; in_valid = 0;
        n_checks++; if ({rdy0, cv0, cm0, vc0, fc0, map0, ffv0, ffe0, ffg0, kill0, halt0} !== '0) begin n_errors++; $display("FAIL midrun_reset: got %h required 0", {rdy0, cv0, cm0, vc0, fc0, map0, ffv0, ffe0, ffg0, kill0, halt0}); end
    endtask

    task automatic test_random();
        logic [4:0] e;
        start = 1; cycle(); start = 0;
        for (int k = 0; k < 400; k++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            va = 4'($urandom); vb = 4'($urandom); op = 3'($urandom);
            e = golden(va, vb, op);
            if ($urandom_range(0, 3) != 0) begin dr = e[3:0]; dz = e[4]; end
            else begin dr = 4'($urandom); dz = 1'($urandom); end
            finish = ($urandom_range(0, 49) == 0);
            start  = ($urandom_range(0, 59) == 0);
            cycle();
            n_checks++;
            if ({rdy0, cv0, cm0, vc0, fc0, map0, ffv0, ffe0, ffg0, kill0, halt0} !==
                {m_run[0], m_cv[0], m_cm[0], m_vec[0], m_fail[0], m_map[0], m_ffv[0], m_ffe[0], m_ffg[0], (m_fail[0] != 0), m_halt[0]}) begin
                n_errors++;
                $display("FAIL rand_u0 step %0d: got %h required %h", k,
                    {rdy0, cv0, cm0, vc0, fc0, map0, ffv0, ffe0, ffg0, kill0, halt0},
                    {m_run[0], m_cv[0], m_cm[0], m_vec[0], m_fail[0], m_map[0], m_ffv[0], m_ffe[0], m_ffg[0], (m_fail[0] != 0), m_halt[0]});
            end
            n_checks++;
            if ({rdy1, halt1, cm1, vc1, fc1, ffv1} !== {m_run[1], m_halt[1], m_cm[1], m_vec[1], m_fail[1], m_ffv[1]}) begin
                n_errors++;
                $display("FAIL rand_u1 step %0d: got %h required %h", k,
                    {rdy1, halt1, cm1, vc1, fc1, ffv1}, {m_run[1], m_halt[1], m_cm[1], m_vec[1], m_fail[1], m_ffv[1]});
            end
            n_checks++;
            if ({vc2, fc2, map2, ffv2, ffg2} !== {m_vec[2][1:0], m_fail[2][1:0], m_map[2], m_ffv[2], m_ffg[2]}) begin
                n_errors++;
                $display("FAIL rand_u2 step %0d: got %h required %h", k,
                    {vc2, fc2, map2, ffv2, ffg2}, {m_vec[2][1:0], m_fail[2][1:0], m_map[2], m_ffv[2], m_ffg[2]});
            end
        end
        start = 0; finish = 0; in_valid = 0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            model_clear(i); m_run[i] = 0; m_halt[i] = 0;
        end
        test_reset();
        test_directed();
        test_stop_on_fail();
        test_saturation();
        test_start_in_halt();
        test_reset_midrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
